// File: rtl/delay_meter_pkg.sv
// delay_meter shared types
// FSM state encoding for the launch/capture sequencer
package delay_meter_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PREP    = 2'd1,
    S_WAIT    = 2'd2,
    S_RECOVER = 2'd3
  } state_e;

endpackage

// File: rtl/delay_meter_sync_ff.sv
// sync_ff: async-reset flop chain
// brings an asynchronous level into the clk domain
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // shift the async input through the chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/delay_meter.sv
// delay_meter: launch a step, time its return
// keeps last/min/max/run statistics of the loop delay
module delay_meter
  import delay_meter_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 1000,
  parameter int SYNC_STAGES = 2,
  parameter bit INVERT      = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  output logic             launch_o,
  input  logic             return_i,
  output logic             busy,
  output logic             done,
  output logic             ok,
  output logic [CNT_W-1:0] delay_cycles,
  output logic [CNT_W-1:0] min_cycles,
  output logic [CNT_W-1:0] max_cycles,
  output logic [CNT_W-1:0] run_count
);

  localparam logic [CNT_W-1:0] LP_TMO = CNT_W'(TIMEOUT - 1);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_cap, w_cap_nxt;
  logic             r_fail, w_fail_nxt;
  logic             w_launch_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_ok_nxt;
  logic             w_ret_sync;
  logic             w_ret_s;
  logic             w_tmo;
  logic             w_upd;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (return_i),
    .o_q (w_ret_sync)
  );

  assign w_ret_s = w_ret_sync ^ INVERT;
  assign w_tmo   = (r_cnt == LP_TMO);
  assign w_upd   = w_done_nxt & w_ok_nxt;

  // sequencer state and run bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_cap    <= '0;
      r_fail   <= 1'b0;
      launch_o <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ok       <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_cap    <= w_cap_nxt;
      r_fail   <= w_fail_nxt;
      launch_o <= w_launch_nxt;
      busy     <= w_busy_nxt;
      done     <= w_done_nxt;
      ok       <= w_ok_nxt;
    end
  end

  // next state: counter clears on every state entry
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + 1'b1;
    w_cap_nxt    = r_cap;
    w_fail_nxt   = r_fail;
    w_launch_nxt = launch_o;
    w_busy_nxt   = busy;
    w_done_nxt   = 1'b0;
    w_ok_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (start) begin
          w_state_nxt = S_PREP;
          w_busy_nxt  = 1'b1;
          w_fail_nxt  = 1'b0;
        end
      end
      S_PREP: begin
        w_launch_nxt = 1'b0;
        if (!w_ret_s) begin
          w_launch_nxt = 1'b1;
          w_state_nxt  = S_WAIT;
          w_cnt_nxt    = '0;
        end else if (w_tmo) begin
          w_fail_nxt  = 1'b1;
          w_state_nxt = S_RECOVER;
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT: begin
        if (w_ret_s) begin
          w_cap_nxt    = r_cnt + 1'b1;
          w_launch_nxt = 1'b0;
          w_state_nxt  = S_RECOVER;
          w_cnt_nxt    = '0;
        end else if (w_tmo) begin
          w_fail_nxt   = 1'b1;
          w_launch_nxt = 1'b0;
          w_state_nxt  = S_RECOVER;
          w_cnt_nxt    = '0;
        end
      end
      S_RECOVER: begin
        w_launch_nxt = 1'b0;
        if (!w_ret_s || w_tmo) begin
          w_fail_nxt  = r_fail | w_ret_s;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_ok_nxt    = ~(r_fail | w_ret_s);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // result registers: clear beats a same-edge update of the stats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delay_cycles <= '0;
      min_cycles   <= '1;
      max_cycles   <= '0;
      run_count    <= '0;
    end else begin
      if (w_upd) delay_cycles <= r_cap;
      if (clear) begin
        min_cycles <= '1;
        max_cycles <= '0;
        run_count  <= '0;
      end else if (w_upd) begin
        if (r_cap < min_cycles) min_cycles <= r_cap;
        if (r_cap > max_cycles) max_cycles <= r_cap;
        if (run_count != '1) run_count <= run_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_delay_meter.sv
// tb_delay_meter: directed checks of delay_meter
// loopback, transport delays, timeouts, reset/start/clear
module tb_delay_meter;

  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic          clear;
  logic          launch_o;
  logic          return_i;
  logic          busy;
  logic          done;
  logic          ok;
  logic [CW-1:0] delay_cycles;
  logic [CW-1:0] min_cycles;
  logic [CW-1:0] max_cycles;
  logic [CW-1:0] run_count;

  int   n_tests;
  int   n_fail;
  int   mode;
  int   dly_ns;
  logic ret_d;
  bit   saw_launch;

  delay_meter #(
    .CNT_W      (CW),
    .TIMEOUT    (20),
    .SYNC_STAGES(2),
    .INVERT     (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .clear       (clear),
    .launch_o    (launch_o),
    .return_i    (return_i),
    .busy        (busy),
    .done        (done),
    .ok          (ok),
    .delay_cycles(delay_cycles),
    .min_cycles  (min_cycles),
    .max_cycles  (max_cycles),
    .run_count   (run_count)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  always @(launch_o) begin
    #(dly_ns);
    ret_d = launch_o;
  end

  always_comb begin
    return_i = 1'b0;
    case (mode)
      0: return_i = launch_o;
      1: return_i = ret_d;
      2: return_i = 1'b0;
      default: return_i = 1'b1;
    endcase
  end

  always @(posedge launch_o) if (mode == 3) saw_launch = 1'b1;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic run_meas(output int cyc, output bit got, output bit okv);
    cyc = 0;
    got = 1'b0;
    okv = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (done) begin
        cyc = i;
        got = 1'b1;
        okv = ok;
        break;
      end
    end
  endtask

  task automatic stats(input string tag, input int d,
                       input int mn, input int mx, input int rc);
    chk({tag, "_delay"}, 32'(delay_cycles), d);
    chk({tag, "_min"},   32'(min_cycles),   mn);
    chk({tag, "_max"},   32'(max_cycles),   mx);
    chk({tag, "_runs"},  32'(run_count),    rc);
  endtask

  int cyc;
  bit got;
  bit okv;
  int extra;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    mode    = 0;
    dly_ns  = 10;
    ret_d   = 1'b0;
    saw_launch = 1'b0;
    rst   = 1'b1;
    start = 1'b0;
    clear = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_launch", 32'(launch_o), 0);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_done",   32'(done), 0);
    chk("rst_ok",     32'(ok), 0);
    stats("rst", 0, 16'hFFFF, 0, 0);

    // 1: zero-delay loopback
    mode = 0;
    run_meas(cyc, got, okv);
    chk("t1_got", 32'(got), 1);
    chk("t1_cyc", cyc, 7);
    chk("t1_ok",  32'(okv), 1);
    stats("t1", 3, 3, 3, 1);

    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    stats("clr", 3, 16'hFFFF, 0, 0);

    // 2: 10 ns transport delay, three runs
    mode   = 1;
    dly_ns = 10;
    for (int r = 0; r < 3; r++) begin
      run_meas(cyc, got, okv);
      chk("t2_got", 32'(got), 1);
      chk("t2_ok",  32'(okv), 1);
      chk("t2_delay", 32'(delay_cycles), 5);
    end
    stats("t2", 5, 5, 5, 3);

    // 3: 10 ns then 30 ns
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    run_meas(cyc, got, okv);
    chk("t3a_ok", 32'(okv), 1);
    chk("t3a_delay", 32'(delay_cycles), 5);
    dly_ns = 30;
    run_meas(cyc, got, okv);
    chk("t3b_ok", 32'(okv), 1);
    stats("t3", 10, 5, 10, 2);

    // 4: return tied low, WAIT timeout
    mode = 2;
    repeat (4) @(negedge clk);
    run_meas(cyc, got, okv);
    chk("t4_got", 32'(got), 1);
    chk("t4_cyc", cyc, 22);
    chk("t4_ok",  32'(okv), 0);
    stats("t4", 10, 5, 10, 2);
    @(negedge clk);
    chk("t4_busy_after", 32'(busy), 0);

    // 6: return stuck high, PREP timeout
    mode = 3;
    repeat (4) @(negedge clk);
    saw_launch = 1'b0;
    run_meas(cyc, got, okv);
    chk("t6_got", 32'(got), 1);
    chk("t6_cyc", cyc, 40);
    chk("t6_ok",  32'(okv), 0);
    chk("t6_nolaunch", 32'(saw_launch), 0);
    stats("t6", 10, 5, 10, 2);

    // 5b: clear coinciding with an ok done
    mode = 0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("t5b_done", 32'(done), 1);
    chk("t5b_ok",   32'(ok), 1);
    stats("t5b", 3, 16'hFFFF, 0, 0);

    // 5a: start during busy is ignored
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5a_busy", 32'(busy), 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk("t5a_got", 32'(got), 1);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy || done) extra++;
    end
    chk("t5a_no_requeue", extra, 0);
    stats("t5a", 3, 3, 3, 1);

    // 5c: reset mid-WAIT
    mode   = 1;
    dly_ns = 30;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5c_launch_pre", 32'(launch_o), 1);
    #1 rst = 1'b1;
    #0.5;
    chk("t5c_launch", 32'(launch_o), 0);
    chk("t5c_busy",   32'(busy), 0);
    stats("t5c", 0, 16'hFFFF, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy || launch_o) extra++;
    end
    chk("t5c_quiet", extra, 0);
    stats("t5c_post", 0, 16'hFFFF, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
